// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Full-duplex UART with TX/RX FIFOs, valid/ready handshakes,
//                configurable data bits, parity and stop bits, and sticky
//                frame/parity/overrun error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int CLOCK_FREQ = 25000000,
    parameter int BAUD_RATE  = 2500000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_LOG2  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [FIFO_LOG2:0]   tx_count,
    output logic [FIFO_LOG2:0]   rx_count,
    output logic                 tx_idle,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    input  logic                 err_clear
);

    localparam int c_DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int c_DEPTH = 1 << FIFO_LOG2;
    localparam int c_BW    = $clog2(c_DIV);

    localparam logic [c_BW-1:0]    c_BAUD_LAST = c_BW'(c_DIV - 1);
    localparam logic [c_BW-1:0]    c_BAUD_ONE  = c_BW'(1);
    localparam logic [c_BW-1:0]    c_SAMP_A    = c_BW'(c_DIV / 2 - 1);
    localparam logic [c_BW-1:0]    c_SAMP_B    = c_BW'(c_DIV / 2);
    localparam logic [c_BW-1:0]    c_SAMP_C    = c_BW'(c_DIV / 2 + 1);
    localparam logic [3:0]         c_DLAST     = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_SLAST     = 4'(STOP_BITS - 1);
    localparam logic [FIFO_LOG2:0] c_FULL      = (FIFO_LOG2 + 1)'(c_DEPTH);
    localparam logic               c_ODD       = (PARITY == 1);
    localparam bit                 c_HAS_PAR   = (PARITY != 0);

    // ------------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Two-flop release synchroniser for the external reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_tx_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_tx_wr, r_tx_rd;
    logic [FIFO_LOG2:0]   r_tx_cnt;
    logic                 w_tx_push, w_tx_pop, w_tx_empty;

    assign tx_ready   = (r_tx_cnt != c_FULL);
    assign w_tx_push  = tx_valid && tx_ready;
    assign w_tx_empty = (r_tx_cnt == '0);
    assign tx_count   = r_tx_cnt;

    // TX storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data;
    end

    // TX pointers and occupancy
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [c_BW-1:0]      r_tx_baud;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 w_tx_tick;

    assign w_tx_tick = (r_tx_baud == c_BAUD_LAST);
    assign tx        = r_tx;
    assign tx_idle   = w_tx_empty && (r_tx_state == TX_IDLE);

    // TX state register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_tx_state <= TX_IDLE;
        else          r_tx_state <= w_tx_state_nxt;
    end

    // TX next state; popping the FIFO coincides with entering START
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_pop       = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_tick) w_tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (w_tx_tick && r_tx_bit == c_DLAST)
                    w_tx_state_nxt = c_HAS_PAR ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                if (w_tx_tick) w_tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (w_tx_tick && r_tx_bit == c_SLAST) begin
                    if (!w_tx_empty) begin
                        w_tx_state_nxt = TX_START;
                        w_tx_pop       = 1'b1;
                    end else begin
                        w_tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX datapath: bit timing, shifter and registered line driver
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            if (w_tx_pop) begin
                r_tx_shift <= r_tx_mem[r_tx_rd];
                r_tx_par   <= (^r_tx_mem[r_tx_rd]) ^ c_ODD;
                r_tx_baud  <= '0;
                r_tx_bit   <= '0;
            end else if (r_tx_state != TX_IDLE) begin
                r_tx_baud <= w_tx_tick ? '0 : r_tx_baud + 1'b1;
                if (w_tx_tick) begin
                    if (r_tx_state == TX_DATA) r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit <= (w_tx_state_nxt != r_tx_state) ? '0 : r_tx_bit + 1'b1;
                end
            end
            case (r_tx_state)
                TX_START:  r_tx <= 1'b0;
                TX_DATA:   r_tx <= r_tx_shift[0];
                TX_PARITY: r_tx <= r_tx_par;
                default:   r_tx <= 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // RX input conditioning
    // ------------------------------------------------------------------------
    logic r_rx_s1, r_rx_s2;

    // Two-flop synchroniser for the asynchronous rx pin
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    // ------------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    rx_state_t            r_rx_state, w_rx_state_nxt;
    logic [c_BW-1:0]      r_rx_baud;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_smp_a, r_smp_b;
    logic                 r_rx_perr;
    logic                 r_rx_push;
    logic                 w_rx_mid, w_rx_maj;

    // States advance at the third sample; the counter free-runs per bit
    assign w_rx_mid = (r_rx_baud == c_SAMP_C);
    assign w_rx_maj = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s2) | (r_smp_b & r_rx_s2);

    // RX state register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_rx_state <= RX_IDLE;
        else          r_rx_state <= w_rx_state_nxt;
    end

    // RX next state, decided at each mid-bit majority sample
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_s2) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (w_rx_mid) w_rx_state_nxt = w_rx_maj ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_rx_mid && r_rx_bit == c_DLAST)
                    w_rx_state_nxt = c_HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (w_rx_mid) w_rx_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (w_rx_mid) w_rx_state_nxt = w_rx_maj ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                if (r_rx_s2) w_rx_state_nxt = RX_IDLE;
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // RX datapath: bit timing, sampling, deserialiser and push request
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_smp_a    <= 1'b1;
            r_smp_b    <= 1'b1;
            r_rx_perr  <= 1'b0;
            r_rx_push  <= 1'b0;
        end else begin
            r_rx_push <= 1'b0;
            // In IDLE the clock of first low detection counts as position 0
            if (r_rx_state == RX_IDLE) begin
                r_rx_baud <= c_BAUD_ONE;
                r_rx_bit  <= '0;
            end else begin
                r_rx_baud <= (r_rx_baud == c_BAUD_LAST) ? '0 : r_rx_baud + 1'b1;
            end
            if (r_rx_baud == c_SAMP_A) r_smp_a <= r_rx_s2;
            if (r_rx_baud == c_SAMP_B) r_smp_b <= r_rx_s2;
            if (w_rx_mid) begin
                case (r_rx_state)
                    RX_START: r_rx_perr <= 1'b0;
                    RX_DATA: begin
                        r_rx_shift <= {w_rx_maj, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                    end
                    RX_PARITY: r_rx_perr <= w_rx_maj ^ (^r_rx_shift) ^ c_ODD;
                    RX_STOP:   r_rx_push <= w_rx_maj;
                    default:   r_rx_push <= 1'b0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_rx_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_rx_wr, r_rx_rd;
    logic [FIFO_LOG2:0]   r_rx_cnt;
    logic                 w_rx_push, w_rx_pop, w_rx_full;

    assign rx_valid  = (r_rx_cnt != '0);
    assign rx_data   = r_rx_mem[r_rx_rd];
    assign rx_count  = r_rx_cnt;
    assign w_rx_pop  = rx_valid && rx_ready;
    assign w_rx_full = (r_rx_cnt == c_FULL);
    // A simultaneous pop frees the slot for a push at full
    assign w_rx_push = r_rx_push && (!w_rx_full || w_rx_pop);

    // RX storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= r_rx_shift;
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    logic w_frm_set, w_par_set, w_ovr_set;
    logic r_err_frame, r_err_parity, r_err_overrun;

    assign w_frm_set   = (r_rx_state == RX_STOP) && w_rx_mid && !w_rx_maj;
    assign w_par_set   = r_rx_push && r_rx_perr;
    assign w_ovr_set   = r_rx_push && w_rx_full && !w_rx_pop;
    assign err_frame   = r_err_frame;
    assign err_parity  = r_err_parity;
    assign err_overrun = r_err_overrun;

    // Flags set on events and hold until err_clear, which wins over a set
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_err_frame   <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else if (err_clear) begin
            r_err_frame   <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_frm_set) r_err_frame   <= 1'b1;
            if (w_par_set) r_err_parity  <= 1'b1;
            if (w_ovr_set) r_err_overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_fifo
//  Description : Directed self-checking bench for uart_fifo (default 8N1
//                instance with optional loopback, plus an even-parity one).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;

    localparam int DIV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic lb      = 1'b0;
    logic sel_p   = 1'b0;
    logic rx_drv  = 1'b1;

    // Default instance
    logic       rx_d, tx_d;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready = 1'b0;
    logic [4:0] tx_count, rx_count;
    logic       tx_idle, err_frame, err_parity, err_overrun;
    logic       err_clear = 1'b0;

    // Even-parity instance
    logic       rx_p, p_tx;
    logic [7:0] p_tx_data = 8'h00;
    logic       p_tx_valid = 1'b0, p_tx_ready;
    logic [7:0] p_rx_data;
    logic       p_rx_valid, p_rx_ready = 1'b0;
    logic [4:0] p_tx_count, p_rx_count;
    logic       p_tx_idle, p_err_frame, p_err_parity, p_err_overrun;
    logic       p_err_clear = 1'b0;

    assign rx_d = lb ? tx_d : (sel_p ? 1'b1 : rx_drv);
    assign rx_p = sel_p ? rx_drv : 1'b1;

    uart_fifo u_dut (
        .clk(clk), .reset_n(reset_n), .rx(rx_d), .tx(tx_d),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count), .tx_idle(tx_idle),
        .err_frame(err_frame), .err_parity(err_parity), .err_overrun(err_overrun),
        .err_clear(err_clear)
    );

    uart_fifo #(.PARITY(2)) u_par (
        .clk(clk), .reset_n(reset_n), .rx(rx_p), .tx(p_tx),
        .tx_data(p_tx_data), .tx_valid(p_tx_valid), .tx_ready(p_tx_ready),
        .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_ready(p_rx_ready),
        .tx_count(p_tx_count), .rx_count(p_rx_count), .tx_idle(p_tx_idle),
        .err_frame(p_err_frame), .err_parity(p_err_parity), .err_overrun(p_err_overrun),
        .err_clear(p_err_clear)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [7:0] q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Collect words popped from the default instance
    always @(negedge clk) begin
        if (rx_valid && rx_ready) q.push_back(rx_data);
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [8:0] d, input int nb, input bit usep,
                        input logic pb, input logic sv);
        rx_drv = 1'b0;
        tick(DIV);
        for (int k = 0; k < nb; k++) begin
            rx_drv = d[k];
            tick(DIV);
        end
        if (usep) begin
            rx_drv = pb;
            tick(DIV);
        end
        rx_drv = sv;
        tick(DIV);
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] fr;
        int   i, guard, n0, maxc;
        bit   saw_full;
        logic rdy;

        // ---------------- reset ----------------
        tick(3);
        check("rst_tx", tx_d, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        reset_n = 1'b1;
        tick(4);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_tx_idle", tx_idle, 1);
        check("rst_errs", {err_frame, err_parity, err_overrun}, 0);
        check("rst_tx_after", tx_d, 1);

        // ---------------- single 0x55 frame, loopback ----------------
        lb = 1'b1;
        fr = {1'b1, 8'h55, 1'b0};
        tx_data = 8'h55; tx_valid = 1'b1;
        tick(1);                                  // edge N: push
        tx_valid = 1'b0;
        check("push_count", tx_count, 1);
        check("n_tx_high", tx_d, 1);
        tick(1);                                  // N+1
        check("n1_tx_high", tx_d, 1);
        tick(1);                                  // N+2
        check("n2_tx_low", tx_d, 0);
        tick(5);                                  // N+7 mid start
        check("bit0", tx_d, fr[0]);
        for (int k = 1; k < 10; k++) begin
            tick(DIV);
            check($sformatf("bit%0d", k), tx_d, fr[k]);
        end
        tick(3);                                  // N+100
        check("frame_busy_99", tx_idle, 0);
        tick(1);                                  // N+101
        check("frame_idle_100", tx_idle, 1);
        tick(5);
        check("lb_rx_valid", rx_valid, 1);
        check("lb_rx_data", rx_data, 8'h55);
        check("lb_rx_count", rx_count, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("lb_pop_count", rx_count, 0);

        // ---------------- 20 back-to-back words ----------------
        q.delete();
        rx_ready = 1'b1;
        i = 0; guard = 0; n0 = 0; maxc = 0; saw_full = 0;
        tx_valid = 1'b1;
        while (i < 20 && guard < 3000) begin
            tx_data = 8'(8'hA0 + i);
            rdy = tx_ready;
            tick(1);
            guard++;
            if (rdy) begin
                if (i == 0) n0 = cyc;
                i++;
            end
            if (int'(tx_count) > maxc) maxc = int'(tx_count);
            if (tx_count == 5'd16 && !tx_ready) saw_full = 1;
        end
        tx_valid = 1'b0;
        check("b2b_pushed", i, 20);
        check("b2b_maxcount", maxc, 16);
        check("b2b_full_seen", saw_full, 1);
        guard = 0;
        while (cyc < n0 + 2000 && guard < 3000) begin
            tick(1);
            guard++;
        end
        check("b2b_busy_2000", tx_idle, 0);
        tick(1);
        check("b2b_idle_2001", tx_idle, 1);
        tick(30);
        rx_ready = 1'b0;
        check("b2b_rx_words", q.size(), 20);
        for (int k = 0; k < 20 && k < q.size(); k++)
            check($sformatf("b2b_word%0d", k), q[k], 8'(8'hA0 + k));

        // ---------------- glitch on idle rx ----------------
        lb = 1'b0;
        tick(5);
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(40);
        check("glitch_rx_count", rx_count, 0);
        check("glitch_err_frame", err_frame, 0);

        // ---------------- frame error then clean frame ----------------
        send(9'h0A5, 8, 0, 1'b0, 1'b0);
        rx_drv = 1'b0;
        tick(50);
        rx_drv = 1'b1;
        tick(20);
        check("ferr_flag", err_frame, 1);
        check("ferr_no_push", rx_count, 0);
        send(9'h03C, 8, 0, 1'b0, 1'b1);
        tick(3);
        check("ferr_next_valid", rx_valid, 1);
        check("ferr_next_data", rx_data, 8'h3C);
        check("ferr_sticky", err_frame, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("ferr_cleared", err_frame, 0);

        // ---------------- overrun ----------------
        for (int k = 0; k < 17; k++) send(9'(8'h10 + k), 8, 0, 1'b0, 1'b1);
        tick(5);
        check("ovr_count", rx_count, 16);
        check("ovr_flag", err_overrun, 1);
        check("ovr_head", rx_data, 8'h10);
        check("ovr_no_other", {err_frame, err_parity}, 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("ovr_pop_head", rx_data, 8'h11);
        check("ovr_pop_count", rx_count, 15);
        check("ovr_sticky_after_pop", err_overrun, 1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("ovr_cleared", err_overrun, 0);
        rx_ready = 1'b1;
        tick(20);
        rx_ready = 1'b0;
        check("ovr_drained", rx_count, 0);

        // ---------------- even parity instance ----------------
        sel_p = 1'b1;
        tick(5);
        send(9'h003, 8, 1, 1'b1, 1'b1);           // 0x03 needs parity 0
        tick(3);
        check("par_data", p_rx_data, 8'h03);
        check("par_err", p_err_parity, 1);
        check("par_count", p_rx_count, 1);
        p_err_clear = 1'b1;
        tick(1);
        p_err_clear = 1'b0;
        check("par_cleared", p_err_parity, 0);
        p_rx_ready = 1'b1;
        tick(1);
        p_rx_ready = 1'b0;
        send(9'h007, 8, 1, 1'b1, 1'b1);           // 0x07 with parity 1 is correct
        tick(3);
        check("par_ok_data", p_rx_data, 8'h07);
        check("par_ok_noerr", {p_err_parity, p_err_frame, p_err_overrun}, 0);
        p_rx_ready = 1'b1;
        tick(1);
        p_rx_ready = 1'b0;
        sel_p = 1'b0;
        p_tx_data = 8'h03; p_tx_valid = 1'b1;
        tick(1);                                  // N
        p_tx_valid = 1'b0;
        tick(97);                                 // N+97: mid parity bit
        check("ptx_parity_03", p_tx, 0);
        tick(10);                                 // mid stop bit
        check("ptx_stop_03", p_tx, 1);
        tick(20);
        p_tx_data = 8'h07; p_tx_valid = 1'b1;
        tick(1);
        p_tx_valid = 1'b0;
        tick(97);
        check("ptx_parity_07", p_tx, 1);
        tick(20);
        check("ptx_idle", {p_tx_idle, p_tx_ready, p_tx_count}, {1'b1, 1'b1, 5'd0});

        // ---------------- reset mid-TX ----------------
        lb = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(30);
        check("midtx_low", tx_d, 0);
        reset_n = 1'b0;
        #1;
        check("midtx_rst_tx", tx_d, 1);
        check("midtx_rst_txcount", tx_count, 0);
        check("midtx_rst_idle", tx_idle, 1);
        tick(2);
        reset_n = 1'b1;
        tick(150);
        check("midtx_no_rx", rx_count, 0);
        check("midtx_rx_valid", rx_valid, 0);
        check("midtx_flags", {err_frame, err_parity, err_overrun}, 0);
        check("midtx_tx_ready", tx_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
